// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the EX stage and the data memory port.
// Forms the effective address, runs one memory handshake per request, and reports writeback or fault.
module lsu_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_valid,
    input  logic              ls_is_store,
    input  logic [DATA_W-1:0] ls_base,
    input  logic [15:0]       ls_offset,
    input  logic [DATA_W-1:0] ls_store_data,
    input  logic [2:0]        ls_dest_reg,
    output logic              stall,
    output logic              wb_valid,
    output logic [2:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic [DATA_W-1:0] fault_addr,
    output logic [DATA_W-1:0] data_memory_a,
    output logic [DATA_W-1:0] data_memory_out_v,
    output logic              data_memory_read,
    output logic              data_memory_write,
    input  logic [DATA_W-1:0] data_memory_in_v,
    input  logic              data_memory_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] L_TO_LAST = TO_W'(TIMEOUT - 1);

    // Effective address: base plus sign-extended 16-bit immediate, wrapping mod 2^DATA_W.
    function automatic logic [DATA_W-1:0] f_ea(input logic [DATA_W-1:0] base,
                                               input logic signed [15:0] off);
        logic signed [DATA_W-1:0] w_off;
        w_off = {{(DATA_W-16){off[15]}}, off};
        return base + w_off;
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic                r_is_store;
    logic [2:0]          r_dest;
    logic [DATA_W-1:0]   r_sdata;
    logic [DATA_W-1:0]   r_addr;
    logic [TO_W-1:0]     r_cnt;
    logic [2:0]          r_wb_reg;
    logic [DATA_W-1:0]   r_wb_data;
    logic [DATA_W-1:0]   r_fault_addr;
    logic [DATA_W-1:0]   w_addr;
    logic                w_misalign;
    logic                w_load_done;

    assign w_addr      = f_ea(ls_base, ls_offset);
    assign w_misalign  = (w_addr[1:0] != 2'b00);
    assign w_load_done = (r_state == S_ACCESS) && data_memory_ready && !r_is_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ls_valid) begin
                    w_next = w_misalign ? S_FAULT : S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A ready arriving on the last allowed cycle still completes the access.
                if (data_memory_ready) begin
                    w_next = S_DONE;
                end else if (r_cnt == L_TO_LAST) begin
                    w_next = S_FAULT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_dest       <= '0;
            r_sdata      <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_wb_reg     <= '0;
            r_wb_data    <= '0;
            r_fault_addr <= '0;
        end else begin
            if (r_state == S_IDLE && ls_valid) begin
                r_is_store <= ls_is_store;
                r_dest     <= ls_dest_reg;
                r_sdata    <= ls_store_data;
                r_addr     <= w_addr;
                r_cnt      <= '0;
                if (w_misalign) begin
                    r_fault_addr <= w_addr;
                end
            end
            if (r_state == S_ACCESS && !data_memory_ready) begin
                if (r_cnt == L_TO_LAST) begin
                    r_fault_addr <= r_addr;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_load_done) begin
                r_wb_reg  <= r_dest;
                r_wb_data <= data_memory_in_v;
            end
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign stall             = (r_state == S_ACCESS) || (r_state == S_IDLE && ls_valid);
    assign data_memory_read  = (r_state == S_ACCESS) && !r_is_store;
    assign data_memory_write = (r_state == S_ACCESS) && r_is_store;
    assign data_memory_a     = r_addr;
    assign data_memory_out_v = r_sdata;
    assign wb_valid          = (r_state == S_DONE) && !r_is_store;
    assign wb_reg            = r_wb_reg;
    assign wb_data           = r_wb_data;
    assign fault             = (r_state == S_FAULT);
    assign fault_addr        = r_fault_addr;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stimulus pushes expected writebacks/faults into a queue,
// a negedge monitor pops and compares whenever the DUT raises wb_valid or fault.
module tb_lsu_ctrl;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              ls_valid;
    logic              ls_is_store;
    logic [31:0]       ls_base;
    logic [15:0]       ls_offset;
    logic [31:0]       ls_store_data;
    logic [2:0]        ls_dest_reg;
    logic              stall;
    logic              wb_valid;
    logic [2:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              fault;
    logic [31:0]       fault_addr;
    logic [31:0]       data_memory_a;
    logic [31:0]       data_memory_out_v;
    logic              data_memory_read;
    logic              data_memory_write;
    logic [31:0]       data_memory_in_v;
    logic              data_memory_ready;

    lsu_ctrl #(.DATA_W(32), .TIMEOUT(16), .TO_W(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ls_valid          (ls_valid),
        .ls_is_store       (ls_is_store),
        .ls_base           (ls_base),
        .ls_offset         (ls_offset),
        .ls_store_data     (ls_store_data),
        .ls_dest_reg       (ls_dest_reg),
        .stall             (stall),
        .wb_valid          (wb_valid),
        .wb_reg            (wb_reg),
        .wb_data           (wb_data),
        .fault             (fault),
        .fault_addr        (fault_addr),
        .data_memory_a     (data_memory_a),
        .data_memory_out_v (data_memory_out_v),
        .data_memory_read  (data_memory_read),
        .data_memory_write (data_memory_write),
        .data_memory_in_v  (data_memory_in_v),
        .data_memory_ready (data_memory_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_fault;
        logic [2:0]  rg;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (wb_valid || fault)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=wb%0d/fault%0d required=none", wb_valid, fault);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_kind", {31'd0, fault}, {31'd0, e.is_fault});
                chk("event_exclusive", {31'd0, wb_valid & fault}, 32'd0);
                if (e.is_fault) begin
                    chk("fault_addr", fault_addr, e.val);
                end else begin
                    chk("wb_reg", {29'd0, wb_reg}, {29'd0, e.rg});
                    chk("wb_data", wb_data, e.val);
                end
            end
        end
    end

    // waits >= 16 means ready never comes (timeout path).
    task automatic run_op(input logic st, input logic [31:0] base, input logic [15:0] off,
                          input logic [31:0] sd, input logic [2:0] dest, input int waits,
                          input logic [31:0] rdata, input logic misal, input logic [31:0] ea);
        exp_t e;
        int   n;
        ls_valid      = 1'b1;
        ls_is_store   = st;
        ls_base       = base;
        ls_offset     = off;
        ls_store_data = sd;
        ls_dest_reg   = dest;
        data_memory_ready = 1'b0;
        if (misal) begin
            e.is_fault = 1'b1; e.rg = 3'd0; e.val = ea; q.push_back(e);
        end else if (waits >= 16) begin
            e.is_fault = 1'b1; e.rg = 3'd0; e.val = ea; q.push_back(e);
        end else if (!st) begin
            e.is_fault = 1'b0; e.rg = dest; e.val = rdata; q.push_back(e);
        end
        @(negedge clk);
        chk("stall_accept", {31'd0, stall}, 32'd1);
        chk("strobe_accept", {30'd0, data_memory_read, data_memory_write}, 32'd0);
        @(posedge clk); #1;
        ls_valid  = 1'b0;
        ls_base   = $urandom;
        ls_offset = 16'h0;
        ls_store_data = $urandom;
        if (!misal) begin
            n = (waits >= 16) ? 16 : waits + 1;
            for (int i = 0; i < n; i++) begin
                if (i == waits) begin
                    data_memory_ready = 1'b1;
                    data_memory_in_v  = rdata;
                end else begin
                    data_memory_ready = 1'b0;
                    data_memory_in_v  = $urandom;
                end
                @(negedge clk);
                chk("stall_access", {31'd0, stall}, 32'd1);
                chk("read_strobe", {31'd0, data_memory_read}, {31'd0, !st});
                chk("write_strobe", {31'd0, data_memory_write}, {31'd0, st});
                chk("mem_addr", data_memory_a, ea);
                if (st) chk("mem_out_v", data_memory_out_v, sd);
                @(posedge clk); #1;
            end
            data_memory_ready = 1'b0;
        end
        @(negedge clk);
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("strobe_done", {30'd0, data_memory_read, data_memory_write}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ls_valid = 1'b0; ls_is_store = 1'b0; ls_base = '0; ls_offset = '0;
        ls_store_data = '0; ls_dest_reg = '0;
        data_memory_in_v = '0; data_memory_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", data_memory_a, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // load, zero wait
        run_op(1'b0, 32'h100, 16'h0004, 32'h0, 3'd3, 0, 32'hDEADBEEF, 1'b0, 32'h104);
        // store, 3 wait states, negative offset
        run_op(1'b1, 32'h200, 16'hFFFC, 32'h12345678, 3'd6, 3, 32'h0, 1'b0, 32'h1FC);
        chk("wb_data_hold", wb_data, 32'hDEADBEEF);
        chk("wb_reg_hold", {29'd0, wb_reg}, 32'd3);
        // misaligned load
        run_op(1'b0, 32'h101, 16'h0000, 32'h0, 3'd1, 0, 32'h0, 1'b1, 32'h101);
        // timeout
        run_op(1'b0, 32'h300, 16'h0010, 32'h0, 3'd2, 99, 32'h0, 1'b0, 32'h310);
        chk("fault_addr_hold", fault_addr, 32'h310);
        // ready on 16th access cycle
        run_op(1'b0, 32'h400, 16'h0008, 32'h0, 3'd5, 15, 32'hCAFEF00D, 1'b0, 32'h408);
        chk("fault_addr_after_late_ready", fault_addr, 32'h310);

        // reset in the middle of an access
        ls_valid = 1'b1; ls_is_store = 1'b0; ls_base = 32'h500; ls_offset = 16'h0;
        ls_dest_reg = 3'd4;
        @(posedge clk); #1;
        ls_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_read", {31'd0, data_memory_read}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read", {31'd0, data_memory_read}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        data_memory_ready = 1'b1;
        data_memory_in_v  = 32'h55555555;
        @(negedge clk);
        chk("post_rst_idle_read", {31'd0, data_memory_read}, 32'd0);
        chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        data_memory_ready = 1'b0;

        // address wrap
        run_op(1'b0, 32'hFFFFFFFC, 16'h0004, 32'h0, 3'd7, 0, 32'h0BADC0DE, 1'b0, 32'h00000000);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
